entropy_pool_arbiter: RTL and testbench

Harvests 8-bit raw samples from the ring-oscillator entropy source (`unstable_counters` output `dat`), health-tests and conditions them into bytes, buffers those bytes in a small pool, and shares the pool between several requesters with round-robin arbitration. It sits between the free-running entropy source and consumers in the core, such as the PRNG seeder and the CPU random-register peripheral. All outputs are registered.

---
 rtl/entropy_pool_arbiter.sv | 134 +++++++++++++
 tb/tb_entropy_pool_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/entropy_pool_arbiter.sv
// Entropy harvester: synchronises raw oscillator bytes, applies a repetition
// health test, folds samples into bytes, pools them and hands them out round-robin.
module entropy_pool_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int SAMPLE_DIV       = 16,
    parameter int SAMPLES_PER_BYTE = 4,
    parameter int POOL_DEPTH       = 4,
    parameter int REP_LIMIT        = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    raw,
    input  logic [NUM_REQ-1:0]            req,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [7:0]                    rnd,
    output logic [$clog2(POOL_DEPTH):0]   pool_count,
    output logic                          health_fail
);
    localparam int          TW  = $clog2(SAMPLE_DIV);
    localparam int          SCW = (SAMPLES_PER_BYTE > 1) ? $clog2(SAMPLES_PER_BYTE) : 1;
    localparam int          RW  = $clog2(REP_LIMIT + 1);
    localparam int          AW  = $clog2(POOL_DEPTH);
    localparam int          CW  = AW + 1;
    localparam int          PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NR  = NUM_REQ;

    logic [7:0]         sync1, sync2;
    logic [TW-1:0]      timer;
    logic               tick;
    logic               first;
    logic [7:0]         prev;
    logic [RW-1:0]      run;
    logic               trip;
    logic               stop;
    logic [7:0]         acc, acc_next;
    logic [SCW-1:0]     scnt;
    logic               byte_done;
    logic [7:0]         mem [POOL_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic               push, pop;
    logic [NUM_REQ-1:0] elig;
    logic [PW-1:0]      ptr, win, cand;
    logic               found;
    int unsigned        scan_idx;
    logic [NUM_REQ-1:0] gnt_next;

    assign tick      = (timer == TW'(SAMPLE_DIV - 1));
    assign acc_next  = {acc[6:0], acc[7]} ^ sync2;
    assign byte_done = tick && (scnt == SCW'(SAMPLES_PER_BYTE - 1));
    // The tripping tick itself already blocks push/grant so the pool reads empty
    // in the same cycle health_fail becomes visible.
    assign trip      = tick && !health_fail && !first && (sync2 == prev)
                       && (run == RW'(REP_LIMIT - 1));
    assign stop      = health_fail || trip;
    assign pop       = found && (pool_count != '0) && !stop;
    assign push      = byte_done && !stop && ((pool_count != CW'(POOL_DEPTH)) || pop);

    always_comb begin
        elig     = req & ~gnt;
        found    = 1'b0;
        win      = '0;
        cand     = '0;
        scan_idx = 0;
        for (int unsigned i = 0; i < NR; i++) begin
            scan_idx = (32'(ptr) + i) % NR;
            cand     = PW'(scan_idx);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        gnt_next = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            gnt_next[i] = pop && (win == PW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= '0;
            sync2       <= '0;
            timer       <= '0;
            first       <= 1'b1;
            prev        <= '0;
            run         <= '0;
            acc         <= '0;
            scnt        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pool_count  <= '0;
            ptr         <= '0;
            gnt         <= '0;
            rnd         <= '0;
            health_fail <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            timer <= tick ? '0 : timer + 1'b1;
            if (tick && !health_fail) begin
                first <= 1'b0;
                prev  <= sync2;
                run   <= (!first && (sync2 == prev)) ? run + 1'b1 : RW'(1);
                if (byte_done) begin
                    acc  <= '0;
                    scnt <= '0;
                end else begin
                    acc  <= acc_next;
                    scnt <= scnt + 1'b1;
                end
            end
            if (trip) health_fail <= 1'b1;
            gnt <= gnt_next;
            if (pop) begin
                rnd    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
                ptr    <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (stop) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                pool_count <= '0;
            end else if (push && !pop) begin
                pool_count <= pool_count + 1'b1;
            end else if (pop && !push) begin
                pool_count <= pool_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= acc_next;
    end
endmodule

// File: tb/tb_entropy_pool_arbiter.sv
// Directed bench for entropy_pool_arbiter: queue-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_entropy_pool_arbiter;
    localparam int NR = 2, SD = 16, SPB = 4, PD = 4, RL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    raw = 8'h00;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] gnt;
    logic [7:0]    rnd;
    logic [2:0]    pool_count;
    logic          health_fail;

    always #5 clk = ~clk;

    entropy_pool_arbiter #(
        .NUM_REQ(NR), .SAMPLE_DIV(SD), .SAMPLES_PER_BYTE(SPB),
        .POOL_DEPTH(PD), .REP_LIMIT(RL)
    ) dut (
        .clk(clk), .rst(rst), .raw(raw), .req(req), .gnt(gnt), .rnd(rnd),
        .pool_count(pool_count), .health_fail(health_fail)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: sample list folded into bytes, byte queue as the pool.
    logic          m_valid = 1'b0;
    int            m_cyc, m_run, m_ptr, m_win, m_idx;
    logic          m_first, m_hf, m_tick, m_trip, m_done, m_full;
    logic [7:0]    m_prev, m_byte, m_rnd;
    logic [NR-1:0] m_gnt;
    logic [7:0]    m_smp[$];
    logic [7:0]    m_pool[$];

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_cyc = 0; m_run = 0; m_ptr = 0; m_first = 1'b1; m_hf = 1'b0;
            m_prev = 8'h00; m_rnd = 8'h00; m_gnt = '0;
            m_smp.delete();
            m_pool.delete();
        end else begin
            m_tick = ((m_cyc % SD) == SD - 1);
            m_trip = 1'b0;
            m_done = 1'b0;
            m_byte = 8'h00;
            if (m_tick && !m_hf) begin
                if (m_first) begin
                    m_first = 1'b0;
                    m_run   = 1;
                end else if (raw == m_prev) begin
                    m_run++;
                    if (m_run >= RL) m_trip = 1'b1;
                end else begin
                    m_run = 1;
                end
                m_prev = raw;
                m_smp.push_back(raw);
                if (m_smp.size() == SPB) begin
                    foreach (m_smp[j]) m_byte = {m_byte[6:0], m_byte[7]} ^ m_smp[j];
                    m_smp.delete();
                    m_done = 1'b1;
                end
            end
            m_win = -1;
            if (!m_hf && !m_trip && m_pool.size() > 0) begin
                for (int i = 0; i < NR; i++) begin
                    m_idx = (m_ptr + i) % NR;
                    if (m_win < 0 && req[m_idx] && !m_gnt[m_idx]) m_win = m_idx;
                end
            end
            m_full = (m_pool.size() == PD);
            m_gnt  = '0;
            if (m_win >= 0) begin
                m_rnd = m_pool.pop_front();
                m_gnt[m_win] = 1'b1;
                m_ptr = (m_win + 1) % NR;
            end
            if (m_done && !m_hf && !m_trip && (!m_full || m_win >= 0)) m_pool.push_back(m_byte);
            if (m_trip) begin
                m_hf = 1'b1;
                m_pool.delete();
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_gnt", 32'(gnt), 32'(m_gnt));
            chk("model_rnd", 32'(rnd), 32'(m_rnd));
            chk("model_pool_count", 32'(pool_count), 32'(m_pool.size()));
            chk("model_health_fail", 32'(health_fail), 32'(m_hf));
        end
    end

    // Each byte is {seed,0,0,0}, which folds to rotl3(seed).
    logic [7:0] samp [0:23];
    logic [7:0] seeds [0:5];
    logic [7:0] bexp [0:4];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic play(input int start, input int n);
        for (int k = 0; k < n; k++) begin
            raw = samp[start + k];
            step(SD);
        end
    endtask

    initial begin
        seeds = '{8'h01, 8'h03, 8'h10, 8'h21, 8'h05, 8'h07};
        bexp  = '{8'h08, 8'h18, 8'h80, 8'h09, 8'h28};
        for (int i = 0; i < 24; i++) samp[i] = (i % 4 == 0) ? seeds[i / 4] : 8'h00;

        // First byte 01,00,00,00 -> 08 visible at cycle 64
        raw = 8'h00;
        do_reset();
        #3;
        chk("reset_pool_count", 32'(pool_count), 0);
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_rnd", 32'(rnd), 0);
        play(0, 4);
        #3;
        chk("first_byte_count", 32'(pool_count), 1);
        req = 2'b01;
        step(1); #3;
        chk("first_byte_gnt", 32'(gnt), 32'h1);
        chk("first_byte_rnd", 32'(rnd), 32'h08);
        req = '0;

        // Full pool, both requesting: strict alternation
        do_reset();
        play(0, 16);
        #3;
        chk("fill_count", 32'(pool_count), 4);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step(1); #3;
            chk("rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_rnd", 32'(rnd), 32'(bexp[k]));
        end
        step(1); #3;
        chk("rr_drained_gnt", 32'(gnt), 0);
        chk("rr_drained_count", 32'(pool_count), 0);
        req = '0;

        // Constant raw trips the repetition test on tick 8
        raw = 8'hA5;
        do_reset();
        step(127); #3;
        chk("hf_before_trip", 32'(health_fail), 0);
        step(1); #3;
        chk("hf_set", 32'(health_fail), 1);
        chk("hf_pool_flushed", 32'(pool_count), 0);
        req = 2'b11;
        step(200);
        req = '0;
        do_reset();
        #3;
        chk("hf_cleared_by_rst", 32'(health_fail), 0);

        // Six bytes with no requests: saturate at four, oldest delivered first
        do_reset();
        play(0, 24);
        #3;
        chk("sat_count", 32'(pool_count), 4);
        req = 2'b01;
        for (int k = 0; k < 4; k++) begin
            step(1); #3;
            chk("sat_gnt", 32'(gnt), 32'h1);
            chk("sat_rnd", 32'(rnd), 32'(bexp[k]));
            step(1); #3;
            chk("sat_gap_gnt", 32'(gnt), 0);
        end
        chk("sat_drained", 32'(pool_count), 0);
        req = '0;

        // Push and pop in the same cycle while full
        do_reset();
        play(0, 16);
        raw = 8'h05;
        step(16);
        raw = 8'h00;
        step(47);
        req = 2'b01;
        step(1); #3;
        chk("pp_gnt", 32'(gnt), 32'h1);
        chk("pp_rnd", 32'(rnd), 32'h08);
        chk("pp_count", 32'(pool_count), 4);
        for (int k = 1; k < 5; k++) begin
            step(2); #3;
            chk("pp_order_rnd", 32'(rnd), 32'(bexp[k]));
        end
        chk("pp_drained", 32'(pool_count), 0);
        req = '0;

        // Reset during a grant pulse
        do_reset();
        play(0, 16);
        req = 2'b01;
        step(1); #3;
        chk("rg_gnt", 32'(gnt), 32'h1);
        chk("rg_count", 32'(pool_count), 3);
        rst = 1'b1;
        req = '0;
        step(1);
        rst = 1'b0;
        #3;
        chk("rg_gnt_cleared", 32'(gnt), 0);
        chk("rg_rnd_cleared", 32'(rnd), 0);
        chk("rg_count_cleared", 32'(pool_count), 0);
        play(0, 3);
        raw = samp[3];
        step(15); #3;
        chk("rg_no_push_63", 32'(pool_count), 0);
        step(1); #3;
        chk("rg_push_64", 32'(pool_count), 1);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
